// File: rtl/scs8hd_chk_pkg.sv
// Shared types and constants for the scs8hd truth-table checker.
// Truth tables are indexed by input vector: bit k holds the expected Y for vector k.
package scs8hd_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } chk_state_e;

    // a211oi: Y = !((A1&A2)|B1|C1), vector bits {C1,B1,A2,A1}
    localparam logic [15:0] SCS8HD_A211OI_TT = 16'h0007;
    // o211ai: Y = !((A1|A2)&B1&C1), same pin ordering
    localparam logic [15:0] SCS8HD_O211AI_TT = 16'h1FFF;

    // One extra bit so a sweep in which every vector fails still fits.
    function automatic int err_cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int settle_cnt_w(input int settle);
        return (settle <= 1) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/scs8hd_tt_checker_if.sv
// Stimulus/response bundle between the checker and the bench driving the cell.
// Optional capture signals exist only with SC_CHK_FAIL_CAPTURE_EN defined.
interface scs8hd_tt_checker_if #(
    parameter int N_IN = 4
);
    logic            START;
    logic [N_IN-1:0] VEC;
    logic            DUT_Y;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [N_IN:0]   ERR_CNT;
`ifdef SC_CHK_FAIL_CAPTURE_EN
    logic            FAIL_VALID;
    logic [N_IN-1:0] FAIL_VEC;
`endif

    modport master (
        output START,
        output DUT_Y,
        input  VEC,
        input  BUSY,
        input  DONE,
        input  PASS,
`ifdef SC_CHK_FAIL_CAPTURE_EN
        input  FAIL_VALID,
        input  FAIL_VEC,
`endif
        input  ERR_CNT
    );

    modport slave (
        input  START,
        input  DUT_Y,
        output VEC,
        output BUSY,
        output DONE,
        output PASS,
`ifdef SC_CHK_FAIL_CAPTURE_EN
        output FAIL_VALID,
        output FAIL_VEC,
`endif
        output ERR_CNT
    );

endinterface

// File: rtl/scs8hd_chk_vecgen.sv
// Input-vector counter plus settle counter for the truth-table checker.
// Requests a sample once the current vector has been held for SETTLE edges.
module scs8hd_chk_vecgen
    import scs8hd_chk_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_drive,
    input  logic            i_sample,
    output logic [N_IN-1:0] o_vec,
    output logic            o_smp_req,
    output logic            o_last
);

    localparam int              CNT_W    = settle_cnt_w(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic [N_IN-1:0]  r_vec;
    logic             w_settled;
    logic             w_last;

    assign w_settled = (r_cnt == CNT_LAST);
    assign w_last    = (r_vec == VEC_LAST);

    // Vector advances on the sample edge; the final vector is held for the result phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_vec <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_vec <= '0;
        end else if (i_sample) begin
            r_cnt <= '0;
            if (!w_last) begin
                r_vec <= r_vec + N_IN'(1);
            end else begin
                r_vec <= r_vec;
            end
        end else if (i_drive) begin
            if (w_settled) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= r_cnt;
            r_vec <= r_vec;
        end
    end

    assign o_vec     = r_vec;
    assign o_smp_req = i_drive && w_settled;
    assign o_last    = w_last;

endmodule

// File: rtl/scs8hd_tt_checker.sv
// Exhaustive truth-table checker for one combinational scs8hd cell.
// Build option SC_CHK_FAIL_CAPTURE_EN adds first-failing-vector capture.
module scs8hd_tt_checker
    import scs8hd_chk_pkg::*;
#(
    parameter int                      N_IN        = 4,
    parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE = SCS8HD_A211OI_TT,
    parameter int                      SETTLE      = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    scs8hd_tt_checker_if.slave    bus
);

    localparam int ERR_W = err_cnt_w(N_IN);

    chk_state_e       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_cnt;
`ifdef SC_CHK_FAIL_CAPTURE_EN
    logic             r_fail_valid;
    logic [N_IN-1:0]  r_fail_vec;
`endif

    logic [N_IN-1:0]  w_vec;
    logic             w_smp_req;
    logic             w_last;
    logic             w_start_acc;
    logic             w_exp_y;
    logic             w_mis;
    logic [ERR_W-1:0] w_err_next;

    scs8hd_chk_vecgen #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_vecgen (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_clr     (w_start_acc),
        .i_drive   (r_state == ST_DRIVE),
        .i_sample  (r_state == ST_SAMPLE),
        .o_vec     (w_vec),
        .o_smp_req (w_smp_req),
        .o_last    (w_last)
    );

    // START only counts when no sweep is running.
    assign w_start_acc = bus.START && ((r_state == ST_IDLE) || (r_state == ST_FIN));

    // Case-equality so an X/Z cell output is a mismatch in 4-state simulation.
    assign w_exp_y    = TRUTH_TABLE[w_vec];
    assign w_mis      = (bus.DUT_Y !== w_exp_y);
    assign w_err_next = r_err_cnt + {{(ERR_W-1){1'b0}}, w_mis};

    // Sweep sequencing, error accumulation and result flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
`ifdef SC_CHK_FAIL_CAPTURE_EN
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (w_start_acc) begin
                        r_state      <= ST_DRIVE;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= '0;
`ifdef SC_CHK_FAIL_CAPTURE_EN
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
`endif
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_DRIVE: begin
                    if (w_smp_req) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_state <= ST_DRIVE;
                    end
                end
                ST_SAMPLE: begin
                    r_err_cnt <= w_err_next;
`ifdef SC_CHK_FAIL_CAPTURE_EN
                    if (w_mis && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_vec   <= w_vec;
                    end else begin
                        r_fail_valid <= r_fail_valid;
                    end
`endif
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state <= ST_DRIVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.VEC     = w_vec;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.PASS    = r_pass;
    assign bus.ERR_CNT = r_err_cnt;
`ifdef SC_CHK_FAIL_CAPTURE_EN
    assign bus.FAIL_VALID = r_fail_valid;
    assign bus.FAIL_VEC   = r_fail_vec;
`endif

endmodule

// File: tb/tb_scs8hd_tt_checker.sv
// Scoreboard bench for scs8hd_tt_checker driving a behavioural a211oi cell model.
module tb_scs8hd_tt_checker;

    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << N;

    typedef struct {
        int err;
        int pass;
        int done_cyc;
        int fvalid;
        int fvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mode = 0;
    logic [15:0] mask = 16'h0000;
    logic x_drv = 1'bx;
    logic prev_done = 1'b0;
    exp_t q[$];

    scs8hd_tt_checker_if #(.N_IN(N)) bus ();

    scs8hd_tt_checker #(
        .N_IN        (N),
        .TRUTH_TABLE (16'h0007),
        .SETTLE      (SETTLE)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic a211oi(input logic [3:0] v);
        return !((v[0] & v[1]) | v[2] | v[3]);
    endfunction

    // mode: 0 good cell, 1 tied low, 2 inverted, 3 X on vector 9, 4 random flips
    function automatic logic cell_y(input logic [3:0] v, input int md, input logic [15:0] mk);
        case (md)
            1: return 1'b0;
            2: return ~a211oi(v);
            3: return (v == 4'd9) ? x_drv : a211oi(v);
            4: return a211oi(v) ^ mk[v];
            default: return a211oi(v);
        endcase
    endfunction

    always_comb bus.DUT_Y = cell_y(bus.VEC, mode, mask);

    function automatic exp_t model(input int md, input logic [15:0] mk, input int t0);
        exp_t e;
        logic [3:0] v;
        e.err = 0; e.fvalid = 0; e.fvec = 0;
        for (int k = 0; k < NVEC; k++) begin
            v = 4'(k);
            if (cell_y(v, md, mk) !== a211oi(v)) begin
                if (e.fvalid == 0) begin e.fvalid = 1; e.fvec = k; end
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.done_cyc = t0 + NVEC * (SETTLE + 1);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rising DONE retires one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.DONE && !prev_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("err_cnt", int'(bus.ERR_CNT), e.err);
                chk("pass", int'(bus.PASS), e.pass);
                chk("busy_at_done", int'(bus.BUSY), 0);
                chk("vec_at_done", int'(bus.VEC), NVEC - 1);
`ifdef SC_CHK_FAIL_CAPTURE_EN
                chk("fail_valid", int'(bus.FAIL_VALID), e.fvalid);
                chk("fail_vec", int'(bus.FAIL_VEC), e.fvec);
`endif
            end
        end
        prev_done <= bus.DONE;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_vec"}, int'(bus.VEC), 0);
        chk({tag, "_busy"}, int'(bus.BUSY), 0);
        chk({tag, "_done"}, int'(bus.DONE), 0);
        chk({tag, "_pass"}, int'(bus.PASS), 0);
        chk({tag, "_err"}, int'(bus.ERR_CNT), 0);
`ifdef SC_CHK_FAIL_CAPTURE_EN
        chk({tag, "_fvalid"}, int'(bus.FAIL_VALID), 0);
        chk({tag, "_fvec"}, int'(bus.FAIL_VEC), 0);
`endif
    endtask

    task automatic start_sweep(input int md, input logic [15:0] mk, input bit hold);
        int t0;
        bit was_done;
        @(negedge clk);
        mode = md;
        mask = mk;
        was_done = bus.DONE;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        q.push_back(model(md, mk, t0));
        if (was_done) begin
            chk("restart_done", int'(bus.DONE), 0);
            chk("restart_err", int'(bus.ERR_CNT), 0);
            chk("restart_vec", int'(bus.VEC), 0);
        end
        chk("start_busy", int'(bus.BUSY), 1);
        if (!hold) bus.START = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.DONE && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'(bus.DONE), 1);
        bus.START = 1'b0;
    endtask

    task automatic sweep(input int md, input logic [15:0] mk, input bit hold);
        start_sweep(md, mk, hold);
        wait_done();
    endtask

    initial begin
        bus.START = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        sweep(0, 16'h0000, 1'b0);
        sweep(1, 16'h0000, 1'b0);
        sweep(2, 16'h0000, 1'b0);
        sweep(3, 16'h0000, 1'b0);

        // Abort a sweep asynchronously while vector 5 is on the pins.
        begin
            int n = 0;
            start_sweep(0, 16'h0000, 1'b0);
            while (bus.VEC != 4'd5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_vec5", int'(bus.VEC), 5);
            #1 rst = 1'b1;
            #1 check_all_zero("midreset");
            void'(q.pop_back());
            #1 rst = 1'b0;
        end

        sweep(0, 16'h0000, 1'b0);
        sweep(0, 16'h0000, 1'b1);
        sweep(0, 16'h0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            sweep(int'($urandom_range(0, 4)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/scs8hd_tt_checker.md
Name: scs8hd_tt_checker

Overview:
- Sequential stimulus/response checker for combinational cells in the scs8hd library; it is the driving and observing end of a cell's input and output pins.
- Walks all 2^N_IN input vectors, waits a settle interval for each, samples the cell output and compares it against a parameterised truth table.
- Reports mismatch count and pass/fail. Used in library bring-up and regression benches; default configuration targets the a211oi function Y = !((A1&A2)|B1|C1).

Parameters:
- N_IN, 4, number of cell inputs driven (1..6).
- TRUTH_TABLE, 16'h0007, expected output; bit k = expected Y for input vector k; width 2^N_IN.
- SETTLE, 2, cycles VEC is held before sampling (>=1).

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  begin a sweep; sampled on CLK rising edge.
- VEC  output  N_IN  driven input vector; bit order {C1,B1,A2,A1} for default a211oi hookup (bit0=A1).
- DUT_Y  input  1  cell output under test.
- BUSY  output  1  sweep in progress.
- DONE  output  1  sweep complete; held until next START or RESET.
- PASS  output  1  DONE && ERR_CNT==0.
- ERR_CNT  output  N_IN+1  mismatch count, range 0..2^N_IN (cannot overflow).

Behaviour:
- Reset (async, immediate): state IDLE; VEC=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, FIN.
- IDLE: START=1 at edge t0 -> DRIVE; VEC=0, ERR_CNT=0, BUSY=1.
- DRIVE: holds VEC for SETTLE edges, then -> SAMPLE.
- SAMPLE (one edge): compare DUT_Y to TRUTH_TABLE[VEC]; a mismatch increments ERR_CNT.
  - DUT_Y X or Z counts as a mismatch (4-state compare).
  - If VEC != 2^N_IN-1: VEC increments, -> DRIVE. Otherwise -> FIN.
- Timing: vector k is sampled at edge t0+(k+1)*(SETTLE+1). The last sample edge sets BUSY=0 and DONE=1. With defaults, DONE rises at edge t0+48.
- FIN: VEC holds its last value; DONE=1.
  - START=1 -> restart exactly as from IDLE: ERR_CNT=0, DONE=0, VEC=0.
- START while BUSY: ignored; no restart, no count change.
- RESET mid-sweep: aborts immediately to the reset values; partial results are lost.
- ERR_CNT changes only on SAMPLE edges and on start/reset.

Optional Feature:
- Macro SC_CHK_FAIL_CAPTURE_EN.
- Defined: adds outputs FAIL_VALID (1) and FAIL_VEC (N_IN).
  - On the first mismatch of a sweep, FAIL_VEC latches VEC and FAIL_VALID=1.
  - Later mismatches do not overwrite it.
  - Both clear to 0 on RESET and on an accepted START.
- Undefined: ports and capture logic are absent; all other behaviour is identical.

Decomposition:
- Package scs8hd_chk_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, FIN);
  - truth-table constants SCS8HD_A211OI_TT=16'h0007 and SCS8HD_O211AI_TT for sibling cells;
  - function computing ERR_CNT width.
- One sub-module, scs8hd_chk_vecgen: vector counter plus settle counter. Emits a sample strobe and a last-vector flag. The top block holds the FSM, comparator, error counter and optional capture.

Test Plan:
- DUT_Y from behavioural a211oi driven by VEC, START pulse at t0: DONE=1 at t0+48, ERR_CNT=0, PASS=1, VEC=4'hF.
- DUT_Y tied 0: ERR_CNT=3 (vectors 0,1,2), PASS=0; with SC_CHK_FAIL_CAPTURE_EN, FAIL_VEC=0 and FAIL_VALID=1.
- DUT_Y = inverted a211oi: ERR_CNT=16 (max, no wrap), PASS=0; with capture, FAIL_VEC=0.
- Correct DUT but DUT_Y forced X during vector 9 only: ERR_CNT=1; with capture, FAIL_VEC=9.
- RESET pulsed mid-sweep (VEC=5, between clock edges): all outputs 0 before the next edge. Re-START gives PASS=1 at 48 cycles.
- START held high throughout sweep: single sweep, DONE at t0+48. START on the cycle after DONE restarts: DONE=0, ERR_CNT=0, VEC=0 next edge.
